// File: rtl/dut_compactor_pkg.sv
// Shared widths, MISR taps/seed, FSM state type and the single-step compaction function
// for the dut result compactor.
package dut_compactor_pkg;
  localparam int DATA_W = 30;
  localparam int CNT_W  = 16;
  localparam logic [DATA_W-1:0] SEED = 30'h0;
  localparam logic [DATA_W-1:0] POLY = 30'h00000053;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Shift left, fold the outgoing MSB back through the taps, then xor in the new word.
  function automatic logic [DATA_W-1:0] misr_next(input logic [DATA_W-1:0] sig,
                                                  input logic [DATA_W-1:0] data);
    return {sig[DATA_W-2:0], 1'b0} ^ (sig[DATA_W-1] ? POLY : '0) ^ data;
  endfunction
endpackage

// File: rtl/dut_result_compactor_if.sv
// Run-control, result-beat and status signals of the compactor.
// COMPACTOR_XMASK_EN adds the xmask run parameter.
interface dut_result_compactor_if;
  import dut_compactor_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  num_vectors;
  logic [DATA_W-1:0] golden;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] signature;
  logic [CNT_W-1:0]  vec_count;
  logic              pass;
`ifdef COMPACTOR_XMASK_EN
  logic [DATA_W-1:0] xmask;

  modport master (output start, num_vectors, golden, xmask, in_valid, in_data,
                  input  in_ready, busy, done, signature, vec_count, pass);
  modport slave  (input  start, num_vectors, golden, xmask, in_valid, in_data,
                  output in_ready, busy, done, signature, vec_count, pass);
`else
  modport master (output start, num_vectors, golden, in_valid, in_data,
                  input  in_ready, busy, done, signature, vec_count, pass);
  modport slave  (input  start, num_vectors, golden, in_valid, in_data,
                  output in_ready, busy, done, signature, vec_count, pass);
`endif
endinterface

// File: rtl/sig_misr.sv
// MISR signature register: load forces SEED, en folds one data word per cycle.
module sig_misr
  import dut_compactor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sig,
  output logic [DATA_W-1:0] sig_next
);
  assign sig_next = misr_next(sig, data);

  always_ff @(posedge clk) begin
    if (rst || load) sig <= SEED;
    else if (en)     sig <= sig_next;
  end
endmodule

// File: rtl/dut_result_compactor.sv
// Folds accepted dut result words into a MISR, counts them and compares the final
// signature with a golden value. Optional COMPACTOR_XMASK_EN masks don't-care bits.
module dut_result_compactor
  import dut_compactor_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  dut_result_compactor_if.slave  bus
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_q, cnt_q;
  logic [DATA_W-1:0] golden_q, fold_data, sig, sig_nxt;
  logic              pass_q, start_acc, beat, last_beat;

`ifdef COMPACTOR_XMASK_EN
  logic [DATA_W-1:0] xmask_q;
  assign fold_data = bus.in_data & ~xmask_q;
`else
  assign fold_data = bus.in_data;
`endif

  assign beat      = bus.in_valid && (state_q == RUN);
  assign start_acc = bus.start && (state_q != RUN);
  // num_q bounds cnt_q, so the increment here can never wrap.
  assign last_beat = beat && ((cnt_q + CNT_W'(1)) == num_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = (bus.num_vectors == '0) ? DONE : RUN;
      RUN:        if (last_beat) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
`ifdef COMPACTOR_XMASK_EN
      xmask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        num_q    <= bus.num_vectors;
        golden_q <= bus.golden;
        cnt_q    <= '0;
        pass_q   <= (bus.num_vectors == '0) && (bus.golden == SEED);
`ifdef COMPACTOR_XMASK_EN
        xmask_q  <= bus.xmask;
`endif
      end else if (beat) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_beat) pass_q <= (sig_nxt == golden_q);
      end
    end
  end

  sig_misr u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc),
    .en       (beat),
    .data     (fold_data),
    .sig      (sig),
    .sig_next (sig_nxt)
  );

  assign bus.in_ready  = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_dut_result_compactor.sv
// Self-checking bench for dut_result_compactor: directed scenarios plus randomized runs
// checked against a cycle-level model that computes the MISR as polynomial reduction.
module tb_dut_result_compactor;
  import dut_compactor_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dut_result_compactor_if bus ();
  dut_result_compactor dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  bit                m_run, m_done, m_pass;
  logic [DATA_W-1:0] m_sig, m_gold, m_mask;
  logic [CNT_W-1:0]  m_cnt, m_num;

  // Multiply by x modulo x^30+x^6+x^4+x+1, then add the data word.
  function automatic logic [DATA_W-1:0] ref_fold(input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W:0] t;
    t = {s, 1'b0};
    if (t[DATA_W]) t = t ^ {1'b1, POLY};
    return t[DATA_W-1:0] ^ d;
  endfunction

  // Advance the model by the inputs currently driven, then cross one rising edge.
  task automatic tick();
    bit beat;
    beat = bus.in_valid && m_run;
    if (rst) begin
      m_run = 0; m_done = 0; m_pass = 0; m_sig = SEED; m_cnt = '0;
    end else if (bus.start && !m_run) begin
      m_num = bus.num_vectors; m_gold = bus.golden; m_sig = SEED; m_cnt = '0;
`ifdef COMPACTOR_XMASK_EN
      m_mask = bus.xmask;
`endif
      if (bus.num_vectors == '0) begin
        m_run = 0; m_done = 1; m_pass = (SEED == bus.golden);
      end else begin
        m_run = 1; m_done = 0; m_pass = 0;
      end
    end else if (beat) begin
      m_sig = ref_fold(m_sig, bus.in_data & ~m_mask);
      m_cnt = m_cnt + 1'b1;
      if (m_cnt == m_num) begin
        m_run = 0; m_done = 1; m_pass = (m_sig == m_gold);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.in_valid = 1; bus.start = 0;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", bus.pass); end
    checks++; if (bus.signature !== SEED) begin errors++; $display("FAIL reset_sig got %h want %h", bus.signature, SEED); end
    checks++; if (bus.vec_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.vec_count); end
    rst = 0; bus.in_valid = 0;
    tick();
  endtask

  task automatic test_single();
    bus.start = 1; bus.num_vectors = 16'd1; bus.golden = 30'h1;
    tick();
    bus.start = 0;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_run got ready=%b busy=%b want 1 1", bus.in_ready, bus.busy); end
    bus.in_valid = 1; bus.in_data = 30'h1;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.signature !== 30'h1) begin errors++; $display("FAIL single_sig got %h want 00000001", bus.signature); end
    checks++; if (bus.vec_count !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", bus.vec_count); end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_done got done=%b busy=%b want 1 0", bus.done, bus.busy); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL single_pass got %b want 1", bus.pass); end
  endtask

  task automatic test_two_beats();
    bus.start = 1; bus.num_vectors = 16'd2; bus.golden = 30'h00000052;
    tick();
    bus.start = 0; bus.in_valid = 1; bus.in_data = 30'h20000000;
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL two_early_done got %b want 0", bus.done); end
    bus.in_data = 30'h0;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.signature !== 30'h00000053) begin errors++; $display("FAIL two_sig got %h want 00000053", bus.signature); end
    checks++; if (bus.signature !== m_sig) begin errors++; $display("FAIL two_sig_model got %h want %h", bus.signature, m_sig); end
    checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin errors++; $display("FAIL two_done_pass got done=%b pass=%b want 1 0", bus.done, bus.pass); end
    checks++; if (bus.vec_count !== 16'd2) begin errors++; $display("FAIL two_cnt got %0d want 2", bus.vec_count); end
  endtask

  task automatic test_zero();
    bus.start = 1; bus.num_vectors = 16'd0; bus.golden = SEED;
    tick();
    bus.start = 0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.done); end
    checks++; if (bus.signature !== SEED) begin errors++; $display("FAIL zero_sig got %h want %h", bus.signature, SEED); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL zero_pass got %b want 1", bus.pass); end
    bus.in_valid = 1; bus.in_data = 30'($urandom()) | 30'h1;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.vec_count !== '0 || bus.signature !== SEED || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL zero_no_beat got cnt=%0d sig=%h ready=%b want 0 %h 0", bus.vec_count, bus.signature, bus.in_ready, SEED);
    end
  endtask

  task automatic test_gaps_restart();
    bus.start = 1; bus.num_vectors = 16'd3; bus.golden = 30'h0;
    tick();
    for (int c = 0; c < 20 && !m_done; c++) begin
      bus.start = (c == 2); bus.num_vectors = 16'd7;
      bus.in_valid = (c % 2 == 0); bus.in_data = 30'($urandom());
      tick();
      checks++; if (bus.done !== m_done || bus.vec_count !== m_cnt) begin
        errors++; $display("FAIL gaps_cycle%0d got done=%b cnt=%0d want %b %0d", c, bus.done, bus.vec_count, m_done, m_cnt);
      end
    end
    bus.start = 0; bus.in_valid = 0;
    checks++; if (!m_done) begin errors++; $display("FAIL gaps_timeout got busy want done"); end
    checks++; if (bus.vec_count !== 16'd3 || bus.signature !== m_sig) begin
      errors++; $display("FAIL gaps_final got cnt=%0d sig=%h want 3 %h", bus.vec_count, bus.signature, m_sig);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    bus.start = 1; bus.num_vectors = 16'd4; bus.golden = 30'h0;
    tick();
    bus.start = 0; bus.in_valid = 1; bus.in_data = 30'($urandom()) | 30'h4;
    tick();
    bus.in_data = 30'($urandom());
    tick();
    bus.in_valid = 0;
    checks++; if (bus.vec_count !== 16'd2) begin errors++; $display("FAIL rmid_cnt got %0d want 2", bus.vec_count); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (bus.signature !== SEED || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_count !== '0) begin
      errors++; $display("FAIL rmid_reset got sig=%h busy=%b done=%b cnt=%0d want %h 0 0 0", bus.signature, bus.busy, bus.done, bus.vec_count, SEED);
    end
    d = 30'($urandom());
    bus.start = 1; bus.num_vectors = 16'd1; bus.golden = ref_fold(SEED, d);
    tick();
    bus.start = 0; bus.in_valid = 1; bus.in_data = d;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.signature !== ref_fold(SEED, d)) begin
      errors++; $display("FAIL rmid_rerun got done=%b pass=%b sig=%h want 1 1 %h", bus.done, bus.pass, bus.signature, ref_fold(SEED, d));
    end
  endtask

  // Back-to-back random runs: each start is issued the cycle after the previous done.
  task automatic test_random_runs();
    logic [DATA_W-1:0] data [0:15];
    logic [DATA_W-1:0] exp_sig;
    int n;
    bit want_pass;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(12, 1);
      exp_sig = SEED;
      for (int i = 0; i < n; i++) begin
        data[i] = 30'($urandom());
        exp_sig = ref_fold(exp_sig, data[i]);
      end
      want_pass = (r % 2 == 0);
      bus.start = 1; bus.num_vectors = CNT_W'(n);
      bus.golden = want_pass ? exp_sig : exp_sig ^ 30'h1;
      tick();
      bus.start = 0;
      for (int c = 0; c < 100 && !m_done; c++) begin
        bus.in_valid = ($urandom_range(3, 0) != 0);
        bus.in_data = data[m_cnt[3:0]];
        tick();
        checks++; if (bus.signature !== m_sig || bus.vec_count !== m_cnt || bus.done !== m_done ||
                      bus.pass !== m_pass || bus.in_ready !== m_run) begin
          errors++; $display("FAIL rand_r%0d_c%0d got sig=%h cnt=%0d done=%b pass=%b rdy=%b want %h %0d %b %b %b",
                             r, c, bus.signature, bus.vec_count, bus.done, bus.pass, bus.in_ready,
                             m_sig, m_cnt, m_done, m_pass, m_run);
        end
      end
      bus.in_valid = 0;
      checks++; if (!m_done || bus.signature !== exp_sig || bus.pass !== want_pass) begin
        errors++; $display("FAIL rand_final_r%0d got sig=%h pass=%b want %h %b", r, bus.signature, bus.pass, exp_sig, want_pass);
      end
    end
  endtask

`ifdef COMPACTOR_XMASK_EN
  task automatic test_xmask();
    bus.start = 1; bus.num_vectors = 16'd1; bus.golden = SEED; bus.xmask = 30'h3FFFFFFF;
    tick();
    bus.start = 0; bus.in_valid = 1; bus.in_data = 30'($urandom()) | 30'h1;
    tick();
    bus.in_valid = 0; bus.xmask = '0;
    checks++; if (bus.signature !== SEED || bus.pass !== 1'b1 || bus.done !== 1'b1) begin
      errors++; $display("FAIL xmask got sig=%h pass=%b done=%b want %h 1 1", bus.signature, bus.pass, bus.done, SEED);
    end
  endtask
`endif

  initial begin
    rst = 1; bus.start = 0; bus.num_vectors = '0; bus.golden = '0;
    bus.in_valid = 0; bus.in_data = '0;
    m_mask = '0; m_num = '0; m_gold = '0;
`ifdef COMPACTOR_XMASK_EN
    bus.xmask = '0;
`endif
    test_reset();
    test_single();
    test_two_beats();
    test_zero();
    test_gaps_restart();
    test_reset_mid();
    test_random_runs();
`ifdef COMPACTOR_XMASK_EN
    test_xmask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
